// File: rtl/mcu_cmd_decoder.sv
// mcu_cmd_decoder
//
// Turns the byte stream from the MCU parallel-bus receiver into framebuffer
// pixel writes and palette writes. Every byte is tagged as either a command
// or a data byte. A command byte always restarts decoding, and any partly
// collected arguments are thrown away. Data bytes supply the arguments for
// SET_X, SET_Y and SET_PALETTE, or the pixel values for WRITE_PIXELS.
// Pixel writes go to an X/Y cursor that advances automatically.
//
// Handshake (framebuffer side): fb_we acts as "valid" and fb_ready as
// "ready". A write completes on a rising sysclk edge where both are high.
// While fb_we=1 and fb_ready=0, fb_x/fb_y/fb_data do not change. If a new
// pixel byte arrives in the same cycle that the old write completes, the new
// write is loaded straight away. If a new pixel byte arrives while the old
// write is still stalled, the new byte is dropped and the overrun flag is set.
//
// Ports:
//   sysclk, rst       clock, asynchronous active-high reset
//   byte_valid        one-cycle strobe; byte_data/byte_is_cmd valid
//   byte_data [7:0]   received byte
//   byte_is_cmd       1 = command byte, 0 = data byte
//   fb_ready          framebuffer accepts the pending write this cycle
//   fb_we             pixel write pending (held until fb_ready)
//   fb_x/fb_y/fb_data pixel address and palette index
//   pal_we            one-cycle palette write strobe
//   pal_index/pal_rgb palette entry and {R,G,B}; hold after the strobe
//   status [2:0]      sticky flags: [0] unknown cmd, [1] range, [2] overrun
//   fsm_state [3:0]   decoder state, for debug:
//                     0 IDLE, 1 ARG_LO, 2 ARG_HI, 3 PIXELS, 4 PAL_IDX,
//                     5 PAL_R, 6 PAL_G, 7 PAL_B, 8 DISCARD
module mcu_cmd_decoder #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int X_W   = 10,
  parameter int Y_W   = 9
) (
  input  logic           sysclk,
  input  logic           rst,
  input  logic           byte_valid,
  input  logic [7:0]     byte_data,
  input  logic           byte_is_cmd,
  input  logic           fb_ready,
  output logic           fb_we,
  output logic [X_W-1:0] fb_x,
  output logic [Y_W-1:0] fb_y,
  output logic [7:0]     fb_data,
  output logic           pal_we,
  output logic [7:0]     pal_index,
  output logic [23:0]    pal_rgb,
  output logic [2:0]     status,
  output logic [3:0]     fsm_state
);

  localparam logic [7:0] CMD_NOP       = 8'h00;
  localparam logic [7:0] CMD_SET_X     = 8'h01;
  localparam logic [7:0] CMD_SET_Y     = 8'h02;
  localparam logic [7:0] CMD_WRITE_PIX = 8'h03;
  localparam logic [7:0] CMD_SET_PAL   = 8'h04;
  localparam logic [7:0] CMD_CLR_STAT  = 8'h05;

  localparam logic [15:0]    X_LIM = 16'(H_RES);
  localparam logic [15:0]    Y_LIM = 16'(V_RES);
  localparam logic [X_W-1:0] X_MAX = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_RES - 1);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    ARG_LO  = 4'd1,
    ARG_HI  = 4'd2,
    PIXELS  = 4'd3,
    PAL_IDX = 4'd4,
    PAL_R   = 4'd5,
    PAL_G   = 4'd6,
    PAL_B   = 4'd7,
    DISCARD = 4'd8
  } state_t;

  state_t state, state_n;

  logic cmd_strobe;
  logic data_strobe;
  assign cmd_strobe  = byte_valid &  byte_is_cmd;
  assign data_strobe = byte_valid & ~byte_is_cmd;

  // Arguments are collected here and are only used once the last byte
  // arrives. Because of that, an abort never needs to clear them.
  logic           arg_is_y;
  logic [7:0]     arg_lo;
  logic [7:0]     pal_idx_s;
  logic [7:0]     pal_r_s;
  logic [7:0]     pal_g_s;
  logic [X_W-1:0] cur_x;
  logic [Y_W-1:0] cur_y;

  logic [15:0] arg_val;
  assign arg_val = {byte_data, arg_lo};

  assign fsm_state = state;

  // State register
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic. A command byte wins in every state.
  always_comb begin
    state_n = state;
    if (cmd_strobe) begin
      unique case (byte_data)
        CMD_SET_X, CMD_SET_Y:   state_n = ARG_LO;
        CMD_WRITE_PIX:          state_n = PIXELS;
        CMD_SET_PAL:            state_n = PAL_IDX;
        CMD_NOP, CMD_CLR_STAT:  state_n = IDLE;
        default:                state_n = DISCARD;
      endcase
    end else if (data_strobe) begin
      unique case (state)
        ARG_LO:  state_n = ARG_HI;
        ARG_HI:  state_n = IDLE;
        PAL_IDX: state_n = PAL_R;
        PAL_R:   state_n = PAL_G;
        PAL_G:   state_n = PAL_B;
        PAL_B:   state_n = IDLE;
        default: state_n = state;   // IDLE, DISCARD ignore; PIXELS stays
      endcase
    end
  end

  // Datapath: cursor, argument staging, registered outputs, status
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      arg_is_y  <= 1'b0;
      arg_lo    <= '0;
      pal_idx_s <= '0;
      pal_r_s   <= '0;
      pal_g_s   <= '0;
      cur_x     <= '0;
      cur_y     <= '0;
      fb_we     <= 1'b0;
      fb_x      <= '0;
      fb_y      <= '0;
      fb_data   <= '0;
      pal_we    <= 1'b0;
      pal_index <= '0;
      pal_rgb   <= '0;
      status    <= '0;
    end else begin
      pal_we <= 1'b0;
      // A write completes when fb_we and fb_ready are both high. A pixel
      // loaded below in the same cycle overrides this clear.
      if (fb_we && fb_ready) fb_we <= 1'b0;

      if (cmd_strobe) begin
        if (byte_data == CMD_SET_X) arg_is_y <= 1'b0;
        if (byte_data == CMD_SET_Y) arg_is_y <= 1'b1;
        if (byte_data == CMD_CLR_STAT) status <= '0;
        if (byte_data > CMD_CLR_STAT) status[0] <= 1'b1;
      end else if (data_strobe) begin
        unique case (state)
          ARG_LO: arg_lo <= byte_data;
          ARG_HI: begin
            if (!arg_is_y) begin
              if (arg_val >= X_LIM) status[1] <= 1'b1;
              else                  cur_x <= arg_val[X_W-1:0];
            end else begin
              if (arg_val >= Y_LIM) status[1] <= 1'b1;
              else                  cur_y <= arg_val[Y_W-1:0];
            end
          end
          PIXELS: begin
            if (fb_we && !fb_ready) begin
              // The previous write is still stalled, so drop this byte.
              status[2] <= 1'b1;
            end else begin
              fb_we   <= 1'b1;
              fb_x    <= cur_x;
              fb_y    <= cur_y;
              fb_data <= byte_data;
              if (cur_x == X_MAX) begin
                cur_x <= '0;
                cur_y <= (cur_y == Y_MAX) ? '0 : cur_y + Y_W'(1);
              end else begin
                cur_x <= cur_x + X_W'(1);
              end
            end
          end
          PAL_IDX: pal_idx_s <= byte_data;
          PAL_R:   pal_r_s   <= byte_data;
          PAL_G:   pal_g_s   <= byte_data;
          PAL_B: begin
            pal_we    <= 1'b1;
            pal_index <= pal_idx_s;
            pal_rgb   <= {pal_r_s, pal_g_s, byte_data};
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mcu_cmd_decoder.sv
module tb_mcu_cmd_decoder;

  localparam int H_RES = 640;
  localparam int V_RES = 480;

  // ---------------- clock / reset ----------------
  logic sysclk = 1'b0;
  logic rst    = 1'b1;
  always #5 sysclk = ~sysclk;

  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data  = 8'h00;
  logic        byte_is_cmd = 1'b0;
  logic        fb_ready   = 1'b1;
  logic        fb_we;
  logic [9:0]  fb_x;
  logic [8:0]  fb_y;
  logic [7:0]  fb_data;
  logic        pal_we;
  logic [7:0]  pal_index;
  logic [23:0] pal_rgb;
  logic [2:0]  status;
  logic [3:0]  fsm_state;

  mcu_cmd_decoder #(.H_RES(H_RES), .V_RES(V_RES), .X_W(10), .Y_W(9)) dut (
    .sysclk(sysclk), .rst(rst),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_is_cmd(byte_is_cmd),
    .fb_ready(fb_ready), .fb_we(fb_we), .fb_x(fb_x), .fb_y(fb_y),
    .fb_data(fb_data), .pal_we(pal_we), .pal_index(pal_index),
    .pal_rgb(pal_rgb), .status(status), .fsm_state(fsm_state)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [26:0] exp_q[$];      // {x, y, data} of each pixel write to be delivered
  logic [31:0] exp_pal_q[$];  // {index, R, G, B}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: the current command, the arguments collected so far,
  // the cursor as plain integers, and whether a write is outstanding.
  int         m_cmd;
  int         m_nargs;
  int         m_args[4];
  int         mx, my;
  logic [2:0] m_status;
  bit         m_pend;

  task automatic model_reset();
    m_cmd = -1; m_nargs = 0; mx = 0; my = 0; m_status = 3'b000; m_pend = 0;
    exp_q.delete();
    exp_pal_q.delete();
  endtask

  // Delivered writes are observed mid-cycle, where the inputs and outputs are
  // both stable.
  always @(negedge sysclk) begin
    if (!rst) begin
      if (fb_we && fb_ready) begin
        check("px_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          logic [26:0] e;
          e = exp_q.pop_front();
          check("px_x", 32'(fb_x), 32'(e[26:17]));
          check("px_y", 32'(fb_y), 32'(e[16:8]));
          check("px_data", 32'(fb_data), 32'(e[7:0]));
        end
      end
      if (pal_we) begin
        check("pal_expected", 32'(exp_pal_q.size() > 0), 32'd1);
        if (exp_pal_q.size() > 0) begin
          logic [31:0] p;
          p = exp_pal_q.pop_front();
          check("pal_index", 32'(pal_index), 32'(p[31:24]));
          check("pal_rgb", 32'(pal_rgb), 32'(p[23:0]));
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Drive one cycle of inputs (called at posedge+1), update the model, and
  // check status after the edge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic c, input logic r);
    bit accept;
    int val;
    byte_valid = v; byte_data = d; byte_is_cmd = c; fb_ready = r;
    accept = 0;
    if (v && c) begin
      m_nargs = 0;
      m_cmd = int'(d);
      if (d == 8'h05) m_status = 3'b000;
      else if (d > 8'h05) m_status[0] = 1'b1;
      if (d == 8'h00 || d >= 8'h05) m_cmd = -1;
    end else if (v) begin
      case (m_cmd)
        1, 2: begin
          m_args[m_nargs] = int'(d);
          m_nargs++;
          if (m_nargs == 2) begin
            val = m_args[1] * 256 + m_args[0];
            if (m_cmd == 1) begin
              if (val >= H_RES) m_status[1] = 1'b1; else mx = val;
            end else begin
              if (val >= V_RES) m_status[1] = 1'b1; else my = val;
            end
            m_cmd = -1;
          end
        end
        3: begin
          if (m_pend && !r) m_status[2] = 1'b1;
          else begin
            accept = 1;
            exp_q.push_back({10'(mx), 9'(my), d});
            mx++;
            if (mx == H_RES) begin
              mx = 0;
              my++;
              if (my == V_RES) my = 0;
            end
          end
        end
        4: begin
          m_args[m_nargs] = int'(d);
          m_nargs++;
          if (m_nargs == 4) begin
            exp_pal_q.push_back({8'(m_args[0]), 8'(m_args[1]), 8'(m_args[2]), d});
            m_cmd = -1;
          end
        end
        default: ;
      endcase
    end
    if (accept) m_pend = 1;
    else if (r) m_pend = 0;
    @(posedge sysclk); #1;
    byte_valid = 1'b0;
    check("status", 32'(status), 32'(m_status));
  endtask

  task automatic send_cmd(input logic [7:0] d, input logic r = 1'b1);
    cycle(1'b1, d, 1'b1, r);
  endtask
  task automatic send_dat(input logic [7:0] d, input logic r = 1'b1);
    cycle(1'b1, d, 1'b0, r);
  endtask
  task automatic idle(input int n, input logic r = 1'b1);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, r);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fb_we"}, 32'(fb_we), 32'd0);
    check({tag, "_fb_x"}, 32'(fb_x), 32'd0);
    check({tag, "_fb_y"}, 32'(fb_y), 32'd0);
    check({tag, "_fb_data"}, 32'(fb_data), 32'd0);
    check({tag, "_pal_we"}, 32'(pal_we), 32'd0);
    check({tag, "_pal_index"}, 32'(pal_index), 32'd0);
    check({tag, "_pal_rgb"}, 32'(pal_rgb), 32'd0);
    check({tag, "_status"}, 32'(status), 32'd0);
    check({tag, "_fsm_idle"}, 32'(fsm_state), 32'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge sysclk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Basic cursor setup and two pixel writes: (16,5)=AA, (17,5)=BB
    send_cmd(8'h01); send_dat(8'h10); send_dat(8'h00);
    send_cmd(8'h02); send_dat(8'h05); send_dat(8'h00);
    send_cmd(8'h03); send_dat(8'hAA); send_dat(8'hBB);
    idle(3);
    check("basic_status", 32'(status), 32'd0);

    // Wrap at the bottom-right corner: (639,479), (0,0), (1,0)
    send_cmd(8'h01); send_dat(8'h7F); send_dat(8'h02);
    send_cmd(8'h02); send_dat(8'hDF); send_dat(8'h01);
    send_cmd(8'h03); send_dat(8'h01); send_dat(8'h02); send_dat(8'h03);
    idle(3);

    // Out-of-range SET_X (640): cursor stays at (2,0), range flag set
    send_cmd(8'h01); send_dat(8'h80); send_dat(8'h02);
    check("range_status", 32'(status), 32'h2);
    send_cmd(8'h03); send_dat(8'h44);
    idle(2);
    send_cmd(8'h05);
    check("clear_status", 32'(status), 32'h0);

    // Palette write, then confirm the values hold after the strobe
    send_cmd(8'h04); send_dat(8'h07); send_dat(8'h11); send_dat(8'h22); send_dat(8'h33);
    idle(3);
    check("pal_hold_we", 32'(pal_we), 32'd0);
    check("pal_hold_index", 32'(pal_index), 32'h07);
    check("pal_hold_rgb", 32'(pal_rgb), 32'h112233);
    // Aborted palette write, then pixels resume at the cursor
    send_cmd(8'h04); send_dat(8'h09); send_dat(8'h09);
    send_cmd(8'h03); send_dat(8'h66);
    idle(3);

    // Overrun: first write is held, second is dropped
    send_cmd(8'h03, 1'b0); send_dat(8'h11, 1'b0); send_dat(8'h22, 1'b0);
    idle(2, 1'b0);
    check("held_we", 32'(fb_we), 32'd1);
    check("held_data", 32'(fb_data), 32'h11);
    check("overrun_flag", 32'(status[2]), 32'd1);
    idle(1, 1'b1);
    send_dat(8'h33);
    idle(3);
    send_cmd(8'h05);

    // Unknown command, then the following data byte is ignored
    send_cmd(8'h7F); send_dat(8'h55);
    idle(2);
    check("unknown_status", 32'(status), 32'h1);
    send_cmd(8'h05);

    // Asynchronous reset in the middle of SET_PALETTE with a write pending
    send_cmd(8'h03, 1'b0); send_dat(8'h5A, 1'b0);
    send_cmd(8'h04, 1'b0); send_dat(8'h01, 1'b0); send_dat(8'h02, 1'b0);
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(posedge sysclk); #1;
    rst = 1'b0;
    send_dat(8'h03); send_dat(8'h04);
    send_cmd(8'h03); send_dat(8'h77);
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic v, c, r;
      logic [7:0] d;
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 5) == 0);
      if (c) d = 8'($urandom_range(0, 7));
      else if ($urandom_range(0, 2) == 0) d = 8'($urandom_range(0, 2));
      else d = 8'($urandom_range(0, 255));
      r = ($urandom_range(0, 3) != 0);
      cycle(v, d, c, r);
    end

    idle(4);
    check("px_queue_drained", 32'(exp_q.size()), 32'd0);
    check("pal_queue_drained", 32'(exp_pal_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
